uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte-producing clients. Each client offers bytes on a valid/ready handshake. The arbiter picks one client, captures its byte, pulses the transmitter's start strobe, and waits for the transmitter to finish the frame before arbitrating again. It sits between the command/status sources and the UART TX shifter; `enable` is the global transmit gate.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: grants the first set bit of 'valid'
// found by searching upward from ptr+1, wrapping around, ending at ptr itself.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Priority search starting just after the last winner.
  // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// Optional packet lock: define UART_TX_ARB_PKT_LOCK_EN to keep the grant on
// one client until it transfers a byte flagged req_last.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         grant_active
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t         state, state_next;
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] cand_valid;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               fire;

`ifdef UART_TX_ARB_PKT_LOCK_EN
  logic          locked;
  logic [IW-1:0] lock_id;

  // While locked, only the owning client may compete.
  always_comb begin
    cand_valid = req_valid;
    if (locked) begin
      cand_valid          = '0;
      cand_valid[lock_id] = req_valid[lock_id];
    end
  end

  // Lock on any byte that is not the end of its packet; unlock on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      lock_id <= '0;
    end else if (fire) begin
      locked  <= !req_last[pick_idx];
      lock_id <= pick_idx;
    end
  end
`else
  assign cand_valid = req_valid;

  logic unused_last;
  assign unused_last = ^req_last;
`endif

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid (cand_valid),
    .ptr   (ptr),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // NOTE: rst_n gates the handshake so req_ready reads zero for the whole reset window, not just after an edge.
  assign fire      = rst_n && (state == ARB) && enable && !tx_busy && pick_any;
  assign req_ready = {NUM_REQ{fire}} & pick_onehot;
  assign tx_start  = (state == LAUNCH);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ARB:       if (fire)     state_next = LAUNCH;
      LAUNCH:                  state_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = ARB;
      default:                 state_next = ARB;
    endcase
  end

  // Capture the granted byte and bookkeeping; ptr starts at the top so client 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= IW'(NUM_REQ - 1);
      tx_data      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
    end else if (fire) begin
      tx_data      <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
      grant_id     <= pick_idx;
      ptr          <= pick_idx;
      grant_active <= 1'b1;
    end else if (state == WAIT_DONE && !tx_busy) begin
      grant_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter busy model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        grant_active;

  int total = 0;
  int bad   = 0;

  int busy_len = 3;
  int busy_cnt;
  logic [7:0] tx_log[$];
  int         hs_q[$];
  int         hs_cnt[4];

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for busy_len cycles after each start strobe; logs launched bytes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= busy_len;
      tx_log.push_back(tx_data);
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  // Handshake monitor.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          hs_q.push_back(i);
          hs_cnt[i] <= hs_cnt[i] + 1;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx_log.delete();
    hs_q.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((grant_active || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (grant_active || tx_busy) begin
      bad++;
      $display("FAIL %s: idle timeout, grant_active=%0b tx_busy=%0b required 0/0", name, grant_active, tx_busy);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'b1111;
    req_last  = '0;
    req_data  = 32'h13121110;
    @(negedge clk);
    total++;
    if ({req_ready, tx_start, tx_data, grant_id, grant_active} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b start=%b data=%h gid=%0d act=%b required all 0",
               req_ready, tx_start, tx_data, grant_id, grant_active);
    end
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    busy_len = 3;
    enable   = 1'b1;
    req_data = 32'h00AA0000;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready: got %b required 0100", req_ready);
    end
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1 || tx_data !== 8'hAA || grant_id !== 2'd2 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL single_launch: start=%b data=%h gid=%0d ready=%b required 1/aa/2/0000",
               tx_start, tx_data, grant_id, req_ready);
    end
    req_valid = '0;
    wait_idle("single_idle", 30);
    total++;
    if (tx_log.size() !== 1) begin
      bad++; $display("FAIL single_pulses: got %0d start pulses required 1", tx_log.size());
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_order[6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
    int n = 0;
    do_reset();
    busy_len  = 20;
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    enable    = 1'b1;
    while (tx_log.size() < 6 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_log.size() < 6) begin
      bad++; $display("FAIL rr_timeout: got %0d frames required 6", tx_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (tx_log[i] !== exp_order[i]) begin
          bad++; $display("FAIL rr_order[%0d]: got %h required %h", i, tx_log[i], exp_order[i]);
        end
      end
    end
    req_valid = '0;
    wait_idle("rr_idle", 40);
  endtask

  task automatic test_enable_gate();
    logic seen = 1'b0;
    do_reset();
    busy_len  = 3;
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    enable    = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (req_ready !== 4'b0000 || tx_start !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL enable_low_quiet: activity seen with enable=0, required none");
    end
    enable = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL enable_rise_ready: got %b required 0001", req_ready);
    end
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'h10) begin
      bad++; $display("FAIL enable_rise_launch: start=%b gid=%0d data=%h required 1/0/10", tx_start, grant_id, tx_data);
    end
    req_valid = '0;
    wait_idle("enable_idle", 30);
  endtask

  task automatic test_enable_drop();
    logic seen = 1'b0;
    int n = 0;
    do_reset();
    busy_len  = 6;
    req_data  = 32'h00005A00;
    req_valid = 4'b0010;
    enable    = 1'b1;
    while (!tx_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!tx_busy) begin
      bad++; $display("FAIL drop_busy_timeout: tx_busy=%b required 1", tx_busy);
    end
    repeat (2) @(negedge clk);
    enable    = 1'b0;
    req_valid = 4'b1111;
    wait_idle("drop_complete", 30);
    repeat (10) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || req_ready !== 4'b0000) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL drop_no_restart: new grant after enable fell, required none");
    end
    total++;
    if (tx_log.size() !== 1 || tx_log[0] !== 8'h5A) begin
      bad++; $display("FAIL drop_frames: got %0d frames required exactly one 5a", tx_log.size());
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    busy_len  = 10;
    req_data  = 32'h13771110;
    req_valid = 4'b0100;
    enable    = 1'b1;
    while (!tx_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    total++;
    if (grant_active !== 1'b1 || grant_id !== 2'd2) begin
      bad++; $display("FAIL mid_in_frame: act=%b gid=%0d required 1/2", grant_active, grant_id);
    end
    req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, tx_start, tx_data, grant_id, grant_active} !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: ready=%b start=%b data=%h gid=%0d act=%b required all 0",
               req_ready, tx_start, tx_data, grant_id, grant_active);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL mid_first_grant: got %b required 0001", req_ready);
    end
    req_valid = '0;
    wait_idle("mid_idle", 30);
  endtask

  task automatic test_lock();
    logic [7:0] pkt[3] = '{8'hB1, 8'hB2, 8'hB3};
`ifdef UART_TX_ARB_PKT_LOCK_EN
    int         exp_id[4]   = '{1, 1, 1, 0};
    logic [7:0] exp_data[4] = '{8'hB1, 8'hB2, 8'hB3, 8'h0C};
`else
    int         exp_id[4]   = '{1, 0, 1, 0};
    logic [7:0] exp_data[4] = '{8'hB1, 8'h0C, 8'hB2, 8'h0C};
`endif
    int base;
    int n1;
    int cyc = 0;
    do_reset();
    busy_len = 3;
    base     = hs_cnt[1];
    enable   = 1'b1;
    req_data = 32'h0000000C;
    while (hs_q.size() < 4 && cyc < 300) begin
      n1 = hs_cnt[1] - base;
      req_valid[1] = (n1 < 3);
      req_data[15:8] = (n1 < 3) ? pkt[n1] : 8'h00;
      req_last[1] = (n1 == 2);
      req_valid[0] = (n1 >= 1);
      req_last[0]  = 1'b1;
      @(negedge clk);
      cyc++;
    end
    req_valid = '0;
    wait_idle("lock_idle", 30);
    total++;
    if (hs_q.size() < 4 || tx_log.size() < 4) begin
      bad++; $display("FAIL lock_timeout: got %0d handshakes %0d frames required 4", hs_q.size(), tx_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (hs_q[i] !== exp_id[i] || tx_log[i] !== exp_data[i]) begin
          bad++;
          $display("FAIL lock_seq[%0d]: client %0d byte %h required client %0d byte %h",
                   i, hs_q[i], tx_log[i], exp_id[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) hs_cnt[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_enable_gate();
    test_enable_drop();
    test_reset_mid();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
